// File: rtl/dac_osc_pkg.sv
// Shared types and constants for the DAC / ring-oscillator sequencer.
// Includes the state encoding, the mode codes and the DAC full-scale value.
package dac_osc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BBM,
    DRIVE,
    MEAS,
    DONE
  } state_t;

  localparam logic [1:0] MODE_RAMP      = 2'd0;
  localparam logic [1:0] MODE_TRI       = 2'd1;
  localparam logic [1:0] MODE_RAMP_CONT = 2'd2;
  localparam logic [1:0] MODE_RO        = 2'd3;

  localparam logic [2:0] DAC_MAX = 3'd7;

endpackage

// File: rtl/dac_osc_sequencer_if.sv
// Config pins in, analog-macro controls out; clk/rst_n stay outside.
// The master side drives the config pins, the slave side is the sequencer.
interface dac_osc_sequencer_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [7:0]       dwell;
  logic             short_req;
  logic             ro_in;
  logic [2:0]       dac_code;
  logic             sel_dac;
  logic             sel_ro;
  logic             sel_short;
  logic             osc_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ro_count;

  modport master (
    output start, stop, mode, dwell, short_req, ro_in,
    input  dac_code, sel_dac, sel_ro, sel_short, osc_en, busy, done, ro_count
  );

  modport slave (
    input  start, stop, mode, dwell, short_req, ro_in,
    output dac_code, sel_dac, sel_ro, sel_short, osc_en, busy, done, ro_count
  );

endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises the free-running ring-osc output and counts its rising edges.
// Latency: SYNC_STAGES+1 cycles from ro_in edge to count; count saturates at all-ones.
module ro_edge_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      count  <= '0;
    end else begin
      sync_q[0] <= ro_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      if (clear) begin
        count <= '0;
      end else if (en && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_osc_sequencer.sv
// Sequences DAC sweeps and ring-osc measurement windows with break-before-make selects.
// Outputs are registered from next-state; start is a level sampled only in IDLE, stop aborts anywhere.
module dac_osc_sequencer
  import dac_osc_pkg::*;
#(
  parameter int BBM_CYCLES  = 4,
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  dac_osc_sequencer_if.slave bus
);

  localparam int BW = $clog2(BBM_CYCLES + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [BW-1:0] BBM_LAST  = BW'(BBM_CYCLES - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t           state_q, state_nxt;
  logic [1:0]       mode_q;
  logic [7:0]       dwell_q;
  logic [BW-1:0]    bbm_q, bbm_nxt;
  logic [7:0]       dcnt_q, dcnt_nxt;
  logic [GW-1:0]    gcnt_q, gcnt_nxt;
  logic [2:0]       code_q, code_nxt;
  logic             up_q, up_nxt;
  logic             launch, cnt_clear, cnt_en, capture;
  logic             sel_dac_q, sel_ro_q, sel_short_q, osc_en_q, busy_q, done_q;
  logic [CNT_W-1:0] ro_count_q, meas_count;

  assign launch = (state_q == IDLE) && bus.start && !bus.stop;
  assign cnt_en = (state_q == MEAS);

  always_comb begin
    state_nxt = state_q;
    bbm_nxt   = bbm_q;
    dcnt_nxt  = dcnt_q;
    gcnt_nxt  = gcnt_q;
    code_nxt  = code_q;
    up_nxt    = up_q;
    cnt_clear = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_nxt = BBM;
          bbm_nxt   = '0;
        end
      end
      BBM: begin
        if (bus.stop) begin
          state_nxt = DONE;
        end else if (bbm_q == BBM_LAST) begin
          if (mode_q == MODE_RO) begin
            state_nxt = MEAS;
            gcnt_nxt  = '0;
            cnt_clear = 1'b1;
          end else begin
            state_nxt = DRIVE;
            code_nxt  = 3'd0;
            up_nxt    = 1'b1;
            dcnt_nxt  = 8'd0;
          end
        end else begin
          bbm_nxt = bbm_q + 1'b1;
        end
      end
      DRIVE: begin
        if (bus.stop) begin
          state_nxt = DONE;
        end else if (dcnt_q != dwell_q) begin
          dcnt_nxt = dcnt_q + 8'd1;
        end else begin
          dcnt_nxt = 8'd0;
          case (mode_q)
            MODE_RAMP: begin
              if (code_q == DAC_MAX) state_nxt = DONE;
              else                   code_nxt  = code_q + 3'd1;
            end
            MODE_TRI: begin
              // The peak is emitted once: turn around straight to DAC_MAX-1.
              if (up_q) begin
                if (code_q == DAC_MAX) begin
                  up_nxt   = 1'b0;
                  code_nxt = DAC_MAX - 3'd1;
                end else begin
                  code_nxt = code_q + 3'd1;
                end
              end else if (code_q == 3'd0) begin
                state_nxt = DONE;
              end else begin
                code_nxt = code_q - 3'd1;
              end
            end
            default: code_nxt = code_q + 3'd1;
          endcase
        end
      end
      MEAS: begin
        if (bus.stop) begin
          state_nxt = DONE;
        end else if (gcnt_q == GATE_LAST) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else begin
          gcnt_nxt = gcnt_q + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != DRIVE) begin
      code_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_RAMP;
      dwell_q <= 8'd0;
      bbm_q   <= '0;
      dcnt_q  <= 8'd0;
      gcnt_q  <= '0;
      code_q  <= 3'd0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      bbm_q   <= bbm_nxt;
      dcnt_q  <= dcnt_nxt;
      gcnt_q  <= gcnt_nxt;
      code_q  <= code_nxt;
      up_q    <= up_nxt;
      if (launch) begin
        mode_q  <= bus.mode;
        dwell_q <= bus.dwell;
      end
    end
  end

  // Selects follow the next state, so BBM and DONE always present an all-low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_dac_q   <= 1'b0;
      sel_ro_q    <= 1'b0;
      sel_short_q <= 1'b0;
      osc_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ro_count_q  <= '0;
    end else begin
      sel_dac_q   <= (state_nxt == DRIVE);
      sel_ro_q    <= (state_nxt == MEAS);
      sel_short_q <= (state_nxt == IDLE) && bus.short_req;
      osc_en_q    <= (state_nxt == MEAS);
      busy_q      <= (state_nxt != IDLE);
      done_q      <= (state_nxt == DONE);
      if (capture) begin
        ro_count_q <= meas_count;
      end
    end
  end

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ro_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_in (bus.ro_in),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (meas_count)
  );

  assign bus.dac_code  = code_q;
  assign bus.sel_dac   = sel_dac_q;
  assign bus.sel_ro    = sel_ro_q;
  assign bus.sel_short = sel_short_q;
  assign bus.osc_en    = osc_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ro_count  = ro_count_q;

endmodule

// File: tb/tb_dac_osc_sequencer.sv
// Directed and randomized sequencer runs checked against a sweep/measurement model.
// A second instance with a 4-bit counter exercises saturation.
module tb_dac_osc_sequencer;

  localparam int BBM  = 4;
  localparam int GATE = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ro_half = 0;
  int   exp_lo = 0;
  int   exp_hi = 0;
  logic [2:0] prev_sel = 3'b000;

  dac_osc_sequencer_if #(.CNT_W(16)) bus ();
  dac_osc_sequencer_if #(.CNT_W(4))  bus_s ();

  dac_osc_sequencer #(
    .BBM_CYCLES(BBM), .GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  dac_osc_sequencer #(
    .BBM_CYCLES(BBM), .GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
  );

  always #5 clk = ~clk;

  always begin
    if (ro_half == 0) begin
      bus.ro_in = 1'b0;
      #7;
    end else begin
      #(ro_half);
      bus.ro_in = ~bus.ro_in;
    end
  end

  always #10 bus_s.ro_in = ~bus_s.ro_in;

  // Selects are one-hot-or-zero and never switch directly from one to another.
  always @(negedge clk) begin
    logic [2:0] cur;
    cur = {bus.sel_dac, bus.sel_ro, bus.sel_short};
    n_cmp++;
    assert ($countones(cur) <= 1 && !(cur != 3'b000 && prev_sel != 3'b000 && cur != prev_sel))
    else begin
      n_err++;
      $error("FAIL sel_excl observed=%b previous=%b expected=one-hot-or-zero with all-low gap", cur, prev_sel);
    end
    prev_sel = cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int drive_len(input int m, input int d);
    return (m == 0) ? 8 * (d + 1) : 15 * (d + 1);
  endfunction

  // Code shown on DRIVE cycle i: each code held d+1 cycles.
  function automatic logic [2:0] exp_code(input int m, input int d, input int i);
    int k;
    k = i / (d + 1);
    if (m == 1) return (k <= 7) ? 3'(k) : 3'(14 - k);
    return 3'(k % 8);
  endfunction

  task automatic run_drive(input int m, input int d, input int stop_at, input logic sr);
    int n;
    bus.short_req = sr;
    tick();
    chk("short_idle", bus.sel_short, sr);
    bus.mode  = 2'(m);
    bus.dwell = 8'(d);
    bus.start = 1'b1;
    tick();
    bus.mode  = 2'($urandom_range(0, 3));
    bus.dwell = 8'($urandom_range(0, 255));
    for (int b = 0; b < BBM; b++) begin
      chk("bbm_sel", {bus.sel_dac, bus.sel_ro, bus.sel_short, bus.osc_en}, 4'b0000);
      chk("bbm_busy", bus.busy, 1'b1);
      tick();
    end
    bus.start = 1'b0;
    n = (stop_at >= 0) ? stop_at : drive_len(m, d);
    for (int i = 0; i < n; i++) begin
      chk("drv_sel", {bus.sel_dac, bus.sel_ro, bus.sel_short, bus.osc_en}, 4'b1000);
      chk("drv_code", bus.dac_code, exp_code(m, d, i));
      if (stop_at >= 0 && i == n - 1) bus.stop = 1'b1;
      tick();
    end
    bus.stop = 1'b0;
    chk("done_pulse", {bus.done, bus.busy}, 2'b11);
    chk("done_outs", {bus.dac_code, bus.sel_dac, bus.sel_ro, bus.sel_short, bus.osc_en}, 0);
    tick();
    chk("back_idle", {bus.done, bus.busy}, 2'b00);
    chk("idle_short", bus.sel_short, sr);
    bus.short_req = 1'b0;
    tick();
  endtask

  task automatic run_meas(input int per, input int stop_at);
    int n;
    ro_half = 5 * per;
    repeat (4) tick();
    bus.mode  = 2'd3;
    bus.dwell = 8'($urandom_range(0, 255));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < BBM; b++) begin
      chk("mbbm_sel", {bus.sel_dac, bus.sel_ro, bus.sel_short, bus.osc_en}, 4'b0000);
      tick();
    end
    n = (stop_at >= 0) ? stop_at : GATE;
    for (int i = 0; i < n; i++) begin
      chk("meas_sel", {bus.sel_dac, bus.sel_ro, bus.sel_short, bus.osc_en}, 4'b0101);
      if (stop_at >= 0 && i == n - 1) bus.stop = 1'b1;
      tick();
    end
    bus.stop = 1'b0;
    chk("mdone_pulse", {bus.done, bus.busy}, 2'b11);
    chk("mdone_outs", {bus.dac_code, bus.sel_dac, bus.sel_ro, bus.sel_short, bus.osc_en}, 0);
    if (stop_at < 0) begin
      exp_lo = GATE / per - 1;
      exp_hi = GATE / per + 1;
    end
    chk_rng("ro_count", int'(bus.ro_count), exp_lo, exp_hi);
    tick();
    chk("mback_idle", {bus.done, bus.busy}, 2'b00);
    chk_rng("ro_count_held", int'(bus.ro_count), exp_lo, exp_hi);
    ro_half = 0;
  endtask

  initial begin
    int m, d, sa, waited;
    bus.start = 0; bus.stop = 0; bus.mode = 0; bus.dwell = 0; bus.short_req = 0;
    bus_s.start = 0; bus_s.stop = 0; bus_s.mode = 0; bus_s.dwell = 0; bus_s.short_req = 0;
    bus_s.ro_in = 0;
    #12;
    chk("reset_outs", {bus.dac_code, bus.sel_dac, bus.sel_ro, bus.sel_short,
                       bus.osc_en, bus.busy, bus.done}, 0);
    chk("reset_cnt", bus.ro_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    repeat (3) begin
      tick();
      chk("start_stop_idle", {bus.busy, bus.sel_dac, bus.done}, 0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();

    run_drive(0, 2, -1, 1'b0);
    run_drive(1, 0, -1, 1'b0);
    run_drive(2, 1, 20, 1'b0);
    run_drive(0, 0, -1, 1'b1);

    repeat (6) begin
      m = $urandom_range(0, 2);
      d = $urandom_range(0, 4);
      if (m == 2) sa = $urandom_range(1, 50);
      else sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, drive_len(m, d) - 1) : -1;
      run_drive(m, d, sa, 1'($urandom_range(0, 1)));
    end

    run_meas(8, -1);
    run_meas(2 * $urandom_range(2, 8), -1);
    run_meas(4, 100);

    bus_s.mode  = 2'd3;
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    waited = 0;
    while (!bus_s.done && waited < 3000) begin
      tick();
      waited++;
    end
    chk("sat_done_seen", bus_s.done, 1'b1);
    chk("sat_count", bus_s.ro_count, 4'd15);
    tick();

    bus.mode  = 2'd0;
    bus.dwell = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (BBM + 10) tick();
    chk("pre_rst_drv", {bus.sel_dac, bus.dac_code}, 4'b1001);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_drv_outs", {bus.dac_code, bus.sel_dac, bus.sel_ro, bus.sel_short,
                         bus.osc_en, bus.busy, bus.done}, 0);
    chk("rst_drv_cnt", bus.ro_count, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_drv_nodone", {bus.done, bus.busy}, 2'b00);
    end

    run_meas(8, -1);
    bus.mode  = 2'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ro_half = 40;
    repeat (BBM + 300) tick();
    chk("pre_rst_meas", {bus.sel_ro, bus.osc_en}, 2'b11);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_meas_outs", {bus.dac_code, bus.sel_dac, bus.sel_ro, bus.sel_short,
                          bus.osc_en, bus.busy, bus.done}, 0);
    chk("rst_meas_cnt", bus.ro_count, 0);
    ro_half = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_meas_nodone", {bus.done, bus.busy}, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
